serial_add: RTL and testbench

Bit-serial ripple adder built from two half-adder cells and a carry flip-flop. It produces one sum bit per clock, LSB first. It sits in the COA datapath upstream of the half-adder cell: it shifts operand bits into the cell and collects the cell's sum and carry outputs. It trades WIDTH cycles of latency for a single-bit adder slice.

---
 rtl/serial_add.sv | 160 ++++++++++++++++
 tb/tb_serial_add.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add : bit-serial ripple adder, one sum bit per clock, LSB first.
// Optional SERIAL_ADD_OVF_EN adds the signed-overflow flag. Rev 1.0
// ---------------------------------------------------------------------------
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic load;
  logic last_bit;

  // Single-bit slice: two cascaded half adders plus the carry flop.
  always_comb begin
    ha0_s = a_q[0] ^ b_q[0];
    ha0_c = a_q[0] & b_q[0];
    ha1_s = ha0_s ^ carry_q;
    ha1_c = ha0_s & carry_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    load     = 1'b0;
    last_bit = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d    = {ha1_s, acc_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = ha0_c | ha1_c;
        cnt_d    = cnt_q + 1'b1;
        last_bit = (cnt_q == C_LAST);
        if (last_bit) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs trail the state by one clock so done lands WIDTH+1 after start.
    busy_d = (state_q == RUN);
    done_d = (state_q == DONE);
    sum_d  = acc_q;
    cout_d = carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic msb_cin_q, msb_cin_d;
  logic ovf_q, ovf_d;

  // Carry entering the MSB is the carry register just before the last bit.
  always_comb begin
    msb_cin_d = msb_cin_q;
    if (load) begin
      msb_cin_d = 1'b0;
    end else if (last_bit) begin
      msb_cin_d = carry_q;
    end
    ovf_d = msb_cin_q ^ carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_cin_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      msb_cin_q <= msb_cin_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_add : self-checking bench for serial_add (WIDTH=8). Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_add;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  int n_vec = 0;
  int n_err = 0;

  serial_add #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    int               mode;   // 0 plain, 1 poke start mid-run
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from signed range.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    logic [WIDTH:0] full;
    int             s;
    logic           ov;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    s    = int'($signed(x)) + int'($signed(y)) + int'(c);
    ov   = (s > (2 ** (WIDTH - 1)) - 1) || (s < -(2 ** (WIDTH - 1)));
    return {ov & OVF_EN, full};
  endfunction

  // Entered at the negedge right after the accepting edge.
  task automatic run_wait(input logic [WIDTH-1:0] es, input logic ec, input logic eo, input int mode,
                          input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb, input logic nc);
    int   busy_cnt = 0;
    logic got_done = 1'b0;
    logic overlap  = 1'b0;
    start = 1'b0;
    for (int k = 1; k <= 20 && !got_done; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) busy_cnt++;
      overlap = overlap | (busy & done);
      if (mode == 1 && k == 4) begin
        a = na; b = nb; cin = nc; start = 1'b1;
      end
      if (mode == 1 && k == 5) start = 1'b0;
      if (mode == 2 && k == WIDTH) begin
        a = na; b = nb; cin = nc; start = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        check("latency", k, WIDTH + 1);
        check("sum", sum, es);
        check("cout", cout, ec);
        check("ovf", ovf, eo);
      end
    end
    check("done_seen", got_done, 1'b1);
    check("busy_cycles", busy_cnt, WIDTH);
    check("busy_done_overlap", overlap, 1'b0);
    if (mode != 2) begin
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      check("sum_hold", sum, es);
      check("cout_hold", cout, ec);
    end
  endtask

  task automatic op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                    input int mode, input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                    input logic nc, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_wait(es, ec, eo, mode, na, nb, nc);
  endtask

  vec_t             vecs[9];
  logic [WIDTH+1:0] m;
  logic [WIDTH-1:0] ra, rb;
  logic             rc;
  logic             saw_done;

  initial begin
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b1, 0, 8'hFF, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 8'hFF, 1'b0, 0, 8'h7F, 1'b1, 1'b1};
    vecs[8] = '{8'h35, 8'h4A, 1'b0, 1, 8'h7F, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mode, 8'hC3, 8'h5A, 1'b1,
         vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf & OVF_EN);
    end

    // Back-to-back: start held in the DONE cycle.
    op(8'h35, 8'h4A, 1'b0, 2, 8'h01, 8'h02, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_wait(8'h03, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0);

    // Asynchronous reset mid-run.
    @(negedge clk);
    a = 8'hA7; b = 8'h6D; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_sum", sum, 8'h00);
    check("arst_cout", cout, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      saw_done = saw_done | done | busy;
    end
    check("no_done_after_abort", saw_done, 1'b0);
    m = model(8'hA7, 8'h6D, 1'b1);
    op(8'hA7, 8'h6D, 1'b1, 0, 8'h00, 8'h00, 1'b0, m[WIDTH-1:0], m[WIDTH], m[WIDTH+1]);

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(1, 0));
      m  = model(ra, rb, rc);
      op(ra, rb, rc, (i % 5 == 0) ? 1 : 0, WIDTH'($urandom), WIDTH'($urandom), 1'b1,
         m[WIDTH-1:0], m[WIDTH], m[WIDTH+1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
